// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART receive-buffer defaults and the stored character layout
package uart_rx_fifo_pkg;
  localparam logic [7:0] DATA_REG_DFT = 8'hff;
  localparam int UART_RXFIFO_DEPTH = 16;
  localparam int UART_RXFIFO_AW = 4;
  localparam int UART_RX_TIMEOUT_TICKS = 640;
  typedef struct packed {
    logic perr;
    logic [7:0] data;
  } rx_char_t;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver-side and register-side signals of the UART receive FIFO
interface uart_rx_fifo_if
  import uart_rx_fifo_pkg::*;
#(
  parameter int AW = UART_RXFIFO_AW
);
  logic rx_en, rx_data_sample, rx_ok, parity_error, rd_data_flag;
  logic [7:0] rxd_out, rd_data;
  logic rd_en, rd_perr, empty, full, thresh_irq, overrun, ovr_clr, timeout_irq, flush;
  logic [AW:0] level, thresh;
  modport master (
    output rx_en, rx_data_sample, rx_ok, rxd_out, parity_error, rd_en, thresh, ovr_clr, flush,
    input rd_data_flag, rd_data, rd_perr, empty, full, level, thresh_irq, overrun, timeout_irq
  );
  modport slave (
    input rx_en, rx_data_sample, rx_ok, rxd_out, parity_error, rd_en, thresh, ovr_clr, flush,
    output rd_data_flag, rd_data, rd_perr, empty, full, level, thresh_irq, overrun, timeout_irq
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x 9-bit storage, synchronous write and asynchronous read
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input logic clk,
  input logic we,
  input logic [AW-1:0] waddr,
  input logic [8:0] wdata,
  input logic [AW-1:0] raddr,
  output logic [8:0] rdata
);
  logic [8:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO capturing one character per frame, with overrun,
// threshold and character-timeout status for the interrupt logic
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = UART_RXFIFO_DEPTH,
  parameter int AW = UART_RXFIFO_AW,
  parameter int TIMEOUT_TICKS = UART_RX_TIMEOUT_TICKS
) (
  input logic clk,
  input logic rst_n,
  uart_rx_fifo_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] ALMOST = (AW+1)'(DEPTH - 1);
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] level_q;
  logic [TW-1:0] tcnt;
  logic [8:0] head;
  rx_char_t wchar;
  logic empty_q, full_q, rx_ok_d, overrun_q, timeout_q;
  logic push, pop, wr, ovr_set, tclr;
  assign push = bus.rx_ok & ~rx_ok_d & bus.rx_en;
  assign pop = bus.rd_en & ~empty_q & ~bus.flush;
  // a push into a full FIFO is only taken when the head leaves in the same cycle
  assign wr = push & (~full_q | pop) & ~bus.flush;
  assign ovr_set = push & full_q & ~pop & ~bus.flush;
  assign tclr = push | bus.rd_en & ~empty_q | bus.flush | empty_q | ~bus.rx_en;
  assign wchar = '{perr: bus.parity_error, data: bus.rxd_out};
  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(wr),
    .waddr(wptr),
    .wdata(wchar),
    .raddr(rptr),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      rx_ok_d <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      tcnt <= '0;
    end else begin
      rx_ok_d <= bus.rx_ok;
      if (bus.flush) begin
        wptr <= '0;
        rptr <= '0;
        level_q <= '0;
        empty_q <= 1'b1;
        full_q <= 1'b0;
      end else begin
        if (wr) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        if (wr != pop) begin
          level_q <= wr ? level_q + 1'b1 : level_q - 1'b1;
          empty_q <= ~wr & (level_q == ONE);
          full_q <= wr & (level_q == ALMOST);
        end
      end
      overrun_q <= ovr_set ? 1'b1 : (bus.ovr_clr | bus.flush) ? 1'b0 : overrun_q;
      tcnt <= tclr ? '0 : (bus.rx_data_sample && tcnt != TMAX) ? tcnt + 1'b1 : tcnt;
      timeout_q <= (bus.rd_en & ~empty_q | bus.flush | empty_q) ? 1'b0 :
                   (~tclr & bus.rx_data_sample & (tcnt == TLAST)) ? 1'b1 : timeout_q;
    end
  assign bus.rd_data_flag = bus.rx_ok;
  assign bus.rd_data = empty_q ? DATA_REG_DFT : head[7:0];
  assign bus.rd_perr = ~empty_q & head[8];
  assign bus.empty = empty_q;
  assign bus.full = full_q;
  assign bus.level = level_q;
  assign bus.overrun = overrun_q;
  assign bus.timeout_irq = timeout_q;
  assign bus.thresh_irq = (bus.thresh != '0) && (level_q >= bus.thresh);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; a queue models the FIFO contents and a
// monitor compares every accepted read against it
module tb_uart_rx_fifo;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic rst_n = 0;
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];
  logic exp_ovr = 0;
  logic exp_to = 0;
  uart_rx_fifo_if #(.AW(4)) bus();
  uart_rx_fifo dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every read the DUT accepts must match the oldest stored character
  always @(negedge clk)
    if (rst_n && bus.rd_en && !bus.empty && !bus.flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra: got %0h expected no data", {bus.rd_perr, bus.rd_data});
      end else
        check("rd_char", {23'd0, bus.rd_perr, bus.rd_data}, {23'd0, exp_q.pop_front()});
    end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flags(input string tag);
    int n = exp_q.size();
    logic [8:0] h = (n != 0) ? exp_q[0] : 9'h0ff;
    check({tag, ".level"}, bus.level, n);
    check({tag, ".empty"}, bus.empty, n == 0);
    check({tag, ".full"}, bus.full, n == DEPTH);
    check({tag, ".overrun"}, bus.overrun, exp_ovr);
    check({tag, ".timeout"}, bus.timeout_irq, exp_to);
    check({tag, ".rd_data"}, bus.rd_data, h[7:0]);
    check({tag, ".rd_perr"}, bus.rd_perr, h[8]);
    check({tag, ".thresh_irq"}, bus.thresh_irq, bus.thresh != 0 && n >= bus.thresh);
  endtask

  task automatic frame(input logic [7:0] d, input logic p, input int hold, input logic with_pop);
    bus.rxd_out = d;
    bus.parity_error = p;
    bus.rx_ok = 1;
    bus.rd_en = with_pop;
    if (bus.rx_en) begin
      if (exp_q.size() < DEPTH || with_pop) exp_q.push_back({p, d});
      else exp_ovr = 1;
    end
    tick(1);
    bus.rd_en = 0;
    if (!with_pop) begin
      @(negedge clk);
      check("rd_data_flag", bus.rd_data_flag, 1);
      check("push_level", bus.level, exp_q.size());
    end
    tick(hold - 1);
    bus.rx_ok = 0;
    bus.rxd_out = 8'($urandom);
    tick(1);
  endtask

  task automatic pop1();
    bus.rd_en = 1;
    tick(1);
    bus.rd_en = 0;
    if (exp_q.size() == 0) exp_to = 0;
  endtask

  task automatic samples(input int n);
    repeat (n) begin
      bus.rx_data_sample = 1;
      tick(1);
      bus.rx_data_sample = 0;
      tick(1);
    end
  endtask

  task automatic do_flush();
    bus.flush = 1;
    tick(1);
    bus.flush = 0;
    exp_q.delete();
    exp_ovr = 0;
    exp_to = 0;
  endtask

  initial begin
    bus.rx_en = 1;
    bus.rx_data_sample = 0;
    bus.rx_ok = 0;
    bus.rxd_out = 0;
    bus.parity_error = 0;
    bus.rd_en = 0;
    bus.thresh = 0;
    bus.ovr_clr = 0;
    bus.flush = 0;
    tick(2);
    @(negedge clk);
    flags("reset");
    check("reset.rd_data_flag", bus.rd_data_flag, 0);
    rst_n = 1;
    tick(1);
    // single frame held for 8 clocks
    frame(8'hA5, 0, 8, 0);
    @(negedge clk); flags("single");
    pop1();
    @(negedge clk); flags("single_pop");
    // fill, overrun, then clear
    for (int i = 0; i < DEPTH; i++) frame(8'(i), 0, $urandom_range(1, 5), 0);
    frame(8'hEE, 0, 2, 0);
    @(negedge clk); flags("overrun");
    bus.ovr_clr = 1; tick(1); bus.ovr_clr = 0; exp_ovr = 0;
    @(negedge clk); flags("ovr_clr");
    // push and pop together while full
    frame(8'h55, 0, 3, 1);
    @(negedge clk); flags("full_pushpop");
    while (exp_q.size() != 0) pop1();
    @(negedge clk); flags("drained");
    // parity flag
    frame(8'h3C, 1, 4, 0);
    @(negedge clk); flags("parity");
    pop1();
    @(negedge clk); flags("parity_pop");
    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      bus.thresh = 5'($urandom_range(0, DEPTH));
      bus.rx_en = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 3))
        0, 1: frame(8'($urandom), 1'($urandom), $urandom_range(1, 5), 1'($urandom_range(0, 3) == 0));
        2: pop1();
        default: begin
          bus.ovr_clr = 1; tick(1); bus.ovr_clr = 0; exp_ovr = 0;
        end
      endcase
      bus.rx_en = 1;
      @(negedge clk); flags("random");
    end
    while (exp_q.size() != 0) pop1();
    bus.thresh = 0;
    @(negedge clk); flags("random_drain");
    // character timeout
    frame(8'h11, 0, 2, 0);
    samples(639);
    @(negedge clk); check("timeout_639", bus.timeout_irq, 0);
    samples(1);
    exp_to = 1;
    @(negedge clk); flags("timeout_640");
    pop1();
    @(negedge clk); flags("timeout_pop");
    frame(8'h22, 0, 2, 0);
    samples(600);
    frame(8'h33, 0, 2, 0);
    samples(639);
    @(negedge clk); check("timeout_1239", bus.timeout_irq, 0);
    samples(1);
    exp_to = 1;
    @(negedge clk); flags("timeout_1240");
    do_flush();
    @(negedge clk); flags("timeout_flush");
    // threshold, overrun and flush
    bus.thresh = 4;
    for (int i = 0; i < 3; i++) frame(8'($urandom), 0, 2, 0);
    @(negedge clk); flags("thresh3");
    frame(8'h44, 0, 2, 0);
    @(negedge clk); flags("thresh4");
    for (int i = 0; i < 13; i++) frame(8'($urandom), 1'($urandom), 1, 0);
    @(negedge clk); flags("thresh_ovr");
    do_flush();
    @(negedge clk); flags("flush");
    // asynchronous reset in the middle of traffic
    for (int i = 0; i < 3; i++) frame(8'($urandom), 1, 2, 0);
    @(posedge clk);
    #3 rst_n = 0;
    exp_q.delete();
    exp_ovr = 0;
    exp_to = 0;
    bus.thresh = 0;
    @(negedge clk); flags("async_reset");
    tick(1);
    rst_n = 1;
    tick(1);
    frame(8'h5A, 0, 3, 0);
    @(negedge clk); flags("after_reset");
    pop1();
    @(negedge clk); flags("after_reset_pop");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
